led7seg_scan: RTL and testbench

LED7SEG_SCAN -- requirements
Module: led7seg_scan

---
 rtl/led7seg_pkg.sv | 26 ++
 rtl/led7seg_hexdec.sv | 11 +
 rtl/led7seg_scan.sv | 164 ++++++++++++++++
 tb/tb_led7seg_scan.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/led7seg_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: decode table, segment
// bit positions and the supported parameter ranges.
package led7seg_pkg;

  localparam int SegCount = 7;
  localparam int SegA = 0;
  localparam int SegB = 1;
  localparam int SegC = 2;
  localparam int SegD = 3;
  localparam int SegE = 4;
  localparam int SegF = 5;
  localparam int SegG = 6;

  localparam int NDigitsMin = 2;
  localparam int NDigitsMax = 8;
  localparam int ClkDivMin  = 8;
  localparam int ClkDivMax  = 1 << 20;
  localparam int GuardMin   = 1;

  // Active-low glyphs, entry k is hex digit k (first element listed is 'F').
  localparam logic [15:0][SegCount-1:0] HexSegLo = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/led7seg_hexdec.sv
// Hex nibble to active-high segment pattern (bit SegA .. SegG).
module led7seg_hexdec
  import led7seg_pkg::*;
(
  input  logic [3:0]          nibble,
  output logic [SegCount-1:0] pattern
);

  assign pattern = ~HexSegLo[nibble];

endmodule

// File: rtl/led7seg_scan.sv
// Time-multiplexed hex display driver with guard blanking, leading-zero blanking
// and a double-buffered (pending/display) digit register committed once per frame.
module led7seg_scan
  import led7seg_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int CLK_DIV        = 50000,
  parameter int GUARD          = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] num,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  lzb_en,
  input  logic                  load,
  output logic [SegCount-1:0]   seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame
);

  localparam int CntW   = $clog2(CLK_DIV);
  localparam int GuardW = $clog2(GUARD + 1);
  localparam int IdxW   = $clog2(N_DIGITS);

  localparam logic [SegCount-1:0] SegOff = {SegCount{SEG_ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0] AnOff  = {N_DIGITS{DIG_ACTIVE_LOW}};

  if (N_DIGITS < NDigitsMin || N_DIGITS > NDigitsMax || CLK_DIV < ClkDivMin ||
      CLK_DIV > ClkDivMax || GUARD < GuardMin || GUARD > CLK_DIV - 2) begin : g_bad_param
    $error("led7seg_scan: parameter out of supported range");
  end

  logic [CntW-1:0]       cnt_q;
  logic [IdxW-1:0]       idx_q;
  logic [GuardW-1:0]     guard_q;
  logic [4*N_DIGITS-1:0] pend_num_q, disp_num_q;
  logic [N_DIGITS-1:0]   pend_dp_q, disp_dp_q;
  logic [N_DIGITS-1:0]   pend_blank_q, disp_blank_q;
  logic                  pend_lzb_q, disp_lzb_q;
  logic                  frame_q;
  logic [SegCount-1:0]   seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;

  logic                  tick, commit, lit_d;
  logic [3:0]            nibs [N_DIGITS];
  logic [3:0]            cur_nib;
  logic [N_DIGITS-1:0]   lzb_dark;
  logic [SegCount-1:0]   pattern;

  assign tick   = (cnt_q == CntW'(CLK_DIV - 1));
  assign commit = tick && (idx_q == IdxW'(N_DIGITS - 1));
  // Reset leaves guard_q = GUARD, so the first slot after reset has the same
  // dark/lit timing as a slot entered through a tick.
  assign lit_d  = !tick && (guard_q <= GuardW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      guard_q <= GuardW'(GUARD);
    end else begin
      cnt_q <= tick ? '0 : cnt_q + CntW'(1);
      if (tick) begin
        idx_q   <= commit ? '0 : idx_q + IdxW'(1);
        guard_q <= GuardW'(GUARD);
      end else if (guard_q != '0) begin
        guard_q <= guard_q - GuardW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_num_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_lzb_q   <= 1'b0;
      disp_num_q   <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      disp_lzb_q   <= 1'b0;
      frame_q      <= 1'b0;
    end else begin
      if (load) begin
        pend_num_q   <= num;
        pend_dp_q    <= dp_in;
        pend_blank_q <= blank_in;
        pend_lzb_q   <= lzb_en;
      end
      // A load coinciding with the commit bypasses pending so it is not lost a frame.
      if (commit) begin
        disp_num_q   <= load ? num      : pend_num_q;
        disp_dp_q    <= load ? dp_in    : pend_dp_q;
        disp_blank_q <= load ? blank_in : pend_blank_q;
        disp_lzb_q   <= load ? lzb_en   : pend_lzb_q;
      end
      frame_q <= commit;
    end
  end

  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lzb_dark   = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      nibs[k] = disp_num_q[4*k +: 4];
    end
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zero_above  = zero_above & (nibs[k] == 4'h0);
      lzb_dark[k] = disp_lzb_q & zero_above;
    end
  end

  assign cur_nib = nibs[idx_q];

  led7seg_hexdec u_hexdec (
    .nibble  (cur_nib),
    .pattern (pattern)
  );

  always_comb begin
    logic [SegCount-1:0] seg_on;
    logic                dp_on;
    logic [N_DIGITS-1:0] an_on;
    seg_on = '0;
    dp_on  = 1'b0;
    an_on  = '0;
    if (lit_d) begin
      an_on[idx_q] = 1'b1;
      if (!disp_blank_q[idx_q]) begin
        dp_on = disp_dp_q[idx_q];
        if (!lzb_dark[idx_q]) begin
          seg_on = pattern;
        end
      end
    end
    seg_d = seg_on ^ SegOff;
    dp_d  = dp_on ^ SEG_ACTIVE_LOW;
    an_d  = an_on ^ AnOff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SegOff;
      dp_q  <= SEG_ACTIVE_LOW;
      an_q  <= AnOff;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg   = seg_q;
  assign dp    = dp_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_led7seg_scan.sv
// Random and directed stimulus for two scanner configurations, checked each cycle
// against a time-based reference model of slot timing, frame commits and glyphs.
module tb_led7seg_scan;

  localparam int NA = 4, CDA = 8,  GA = 2;
  localparam int NB = 3, CDB = 10, GB = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] num_v = '0;
  logic [7:0]  dp_v = '0, blank_v = '0;
  logic        lzb_v = 1'b0, load_v = 1'b0;

  logic [6:0]    seg_a, seg_b;
  logic          dp_a, dp_b, frame_a, frame_b;
  logic [NA-1:0] an_a;
  logic [NB-1:0] an_b;

  always #5 clk = ~clk;

  led7seg_scan #(
    .N_DIGITS(NA), .CLK_DIV(CDA), .GUARD(GA), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .num(num_v[4*NA-1:0]), .dp_in(dp_v[NA-1:0]),
    .blank_in(blank_v[NA-1:0]), .lzb_en(lzb_v), .load(load_v),
    .seg(seg_a), .dp(dp_a), .an(an_a), .frame(frame_a)
  );

  led7seg_scan #(
    .N_DIGITS(NB), .CLK_DIV(CDB), .GUARD(GB), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .num(num_v[4*NB-1:0]), .dp_in(dp_v[NB-1:0]),
    .blank_in(blank_v[NB-1:0]), .lzb_en(lzb_v), .load(load_v),
    .seg(seg_b), .dp(dp_b), .an(an_b), .frame(frame_b)
  );

  int cfg_n [2]   = '{NA, NB};
  int cfg_cd [2]  = '{CDA, CDB};
  int cfg_g [2]   = '{GA, GB};
  bit cfg_sal [2] = '{1'b1, 1'b0};
  bit cfg_dal [2] = '{1'b1, 1'b0};

  logic [31:0] pend_num [2], disp_num [2];
  logic [7:0]  pend_dp [2], disp_dp [2], pend_bl [2], disp_bl [2];
  logic        pend_lzb [2], disp_lzb [2];
  int          e;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, e, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_lo(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [31:0] nmask(input int id);
    logic [63:0] m;
    m = (64'd1 << (4 * cfg_n[id])) - 64'd1;
    return m[31:0];
  endfunction

  function automatic logic [7:0] dmask(input int id);
    logic [15:0] m;
    m = (16'd1 << cfg_n[id]) - 16'd1;
    return m[7:0];
  endfunction

  task automatic model_reset();
    e = 0;
    for (int id = 0; id < 2; id++) begin
      pend_num[id] = '0; pend_dp[id] = '0; pend_bl[id] = '0; pend_lzb[id] = 1'b0;
      disp_num[id] = '0; disp_dp[id] = '0; disp_bl[id] = '0; disp_lzb[id] = 1'b0;
    end
  endtask

  // Edge e is a frame boundary whenever a whole number of frames has elapsed.
  task automatic model_edge();
    e++;
    for (int id = 0; id < 2; id++) begin
      if (e % (cfg_cd[id] * cfg_n[id]) == 0) begin
        disp_num[id] = load_v ? (num_v & nmask(id))   : pend_num[id];
        disp_dp[id]  = load_v ? (dp_v & dmask(id))    : pend_dp[id];
        disp_bl[id]  = load_v ? (blank_v & dmask(id)) : pend_bl[id];
        disp_lzb[id] = load_v ? lzb_v                 : pend_lzb[id];
      end
      if (load_v) begin
        pend_num[id] = num_v & nmask(id);
        pend_dp[id]  = dp_v & dmask(id);
        pend_bl[id]  = blank_v & dmask(id);
        pend_lzb[id] = lzb_v;
      end
    end
  endtask

  function automatic void expect_out(input int id, output logic [7:0] an_e,
                                     output logic [6:0] seg_e, output logic dp_e,
                                     output logic fr_e);
    int p, d;
    logic [7:0] an_on;
    logic [6:0] seg_on;
    logic dp_on;
    p = e % cfg_cd[id];
    d = (e / cfg_cd[id]) % cfg_n[id];
    an_on = '0; seg_on = '0; dp_on = 1'b0;
    if (p >= cfg_g[id]) begin
      an_on[d] = 1'b1;
      if (!disp_bl[id][d]) begin
        dp_on = disp_dp[id][d];
        if (!(disp_lzb[id] && d > 0 && (disp_num[id] >> (4 * d)) == 32'd0))
          seg_on = ~seg_lo(disp_num[id][4*d +: 4]);
      end
    end
    seg_e = cfg_sal[id] ? ~seg_on : seg_on;
    dp_e  = dp_on ^ cfg_sal[id];
    an_e  = cfg_dal[id] ? (~an_on & dmask(id)) : an_on;
    fr_e  = (e > 0) && (e % (cfg_cd[id] * cfg_n[id]) == 0);
  endfunction

  task automatic compare_all();
    logic [7:0] an_e;
    logic [6:0] seg_e;
    logic dp_e, fr_e;
    expect_out(0, an_e, seg_e, dp_e, fr_e);
    check("A.an", 32'(an_a), 32'(an_e));
    check("A.seg", 32'(seg_a), 32'(seg_e));
    check("A.dp", 32'(dp_a), 32'(dp_e));
    check("A.frame", 32'(frame_a), 32'(fr_e));
    expect_out(1, an_e, seg_e, dp_e, fr_e);
    check("B.an", 32'(an_b), 32'(an_e));
    check("B.seg", 32'(seg_b), 32'(seg_e));
    check("B.dp", 32'(dp_b), 32'(dp_e));
    check("B.frame", 32'(frame_b), 32'(fr_e));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load_once(input logic [31:0] n, input logic [7:0] d, input logic [7:0] b,
                           input logic z);
    num_v = n; dp_v = d; blank_v = b; lzb_v = z; load_v = 1'b1;
    cycle();
    load_v = 1'b0;
  endtask

  initial begin
    model_reset();
    run(3);
    #1 rst_n = 1'b1;

    load_once(32'h1234, 8'h00, 8'h00, 1'b0);
    run(80);
    load_once(32'h00A0, 8'h00, 8'h00, 1'b1);
    run(80);
    load_once(32'h0000, 8'h04, 8'h00, 1'b1);
    run(80);
    load_once(32'h1111, 8'h00, 8'h00, 1'b0);
    run(10);
    load_once(32'h2222, 8'h00, 8'h00, 1'b0);
    run(80);
    load_once(32'h8888, 8'h00, 8'h00, 1'b0);
    run(80);
    load_once(32'h5678, 8'hFF, 8'h02, 1'b0);
    run(13);
    load_once(32'h9ABC, 8'h01, 8'h00, 1'b0);

    // Short asynchronous reset pulse in the middle of a slot.
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare_all();
    rst_n = 1'b1;
    run(80);

    for (int i = 0; i < 2000; i++) begin
      load_v = ($urandom_range(15) == 0);
      if (load_v) begin
        num_v   = $urandom >> $urandom_range(31);
        dp_v    = 8'($urandom);
        blank_v = 8'($urandom & $urandom & $urandom);
        lzb_v   = 1'($urandom);
      end
      cycle();
    end
    load_v = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
